// File: rtl/glb_pkg.sv
// Global buffer shared definitions: geometry and word/byte-enable types.
package glb_pkg;

  localparam int unsigned GLB_DEPTH  = 16384;
  localparam int unsigned GLB_ADDR_W = 14;
  localparam int unsigned GLB_DATA_W = 32;
  localparam int unsigned GLB_BYTES  = 4;

  typedef logic [GLB_DATA_W-1:0] glb_word_t;
  typedef logic [GLB_BYTES-1:0]  glb_web_t;

endpackage : glb_pkg

// File: rtl/sram_64kb.sv
// sram_64kb: 16384 x 32-bit single-port global buffer, per-byte active-low
// write enables, one-cycle registered read, out-of-range access flag.
// Optional build macro GLB_WRITE_FIRST_EN: same-address read-during-write
// returns the merged new word instead of the pre-write word.
// Note: rst_n is an active-high asynchronous reset despite its name.
module sram_64kb
  import glb_pkg::*;
#(
  parameter int unsigned DEPTH  = GLB_DEPTH,
  parameter int unsigned ADDR_W = GLB_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  glb_web_t              WEB,
  input  logic [31:0]           addr,
  input  glb_word_t             write_data,
  output glb_word_t             read_data,
  output logic                  addr_err
);

  // Word storage; never reset so preloaded contents survive reset.
  glb_word_t memory [0:DEPTH-1];

  logic [ADDR_W-1:0] idx_c;
  logic              in_range_c;
  logic              wr_any_c;
  glb_word_t         rd_word_c;

  // Replace only the lanes whose enable is driven low; anything else keeps old.
  function automatic glb_word_t merge(input glb_word_t old,
                                      input glb_word_t wdata,
                                      input glb_web_t  web);
    glb_word_t m;
    m = old;
    for (int i = 0; i < int'(GLB_BYTES); i++) begin
      if (web[i] == 1'b0) begin
        m[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    return m;
  endfunction

  // Address decode and read-word selection.
  always_comb begin
    idx_c      = addr[ADDR_W-1:0];
    in_range_c = (addr[31:ADDR_W] == '0);
    wr_any_c   = (WEB != '1);
`ifdef GLB_WRITE_FIRST_EN
    rd_word_c  = merge(memory[idx_c], write_data, WEB);
`else
    rd_word_c  = memory[idx_c];
`endif
  end

  // Lane-masked write; suppressed while reset is asserted or address is out of range.
  always_ff @(posedge clk) begin
    if (!rst_n && in_range_c && wr_any_c) begin
      memory[idx_c] <= merge(memory[idx_c], write_data, WEB);
    end
  end

  // Registered read port and error flag, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      read_data <= '0;
      addr_err  <= 1'b0;
    end else begin
      read_data <= in_range_c ? rd_word_c : '0;
      addr_err  <= !in_range_c;
    end
  end

endmodule : sram_64kb

// File: tb/tb_sram_64kb.sv
// Self-checking bench for sram_64kb: scoreboard queue of expected read results.
module tb_sram_64kb;
  import glb_pkg::*;

  logic        clk;
  logic        rst_n;
  glb_web_t    WEB;
  logic [31:0] addr;
  glb_word_t   write_data;
  glb_word_t   read_data;
  logic        addr_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  sram_64kb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WEB        (WEB),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one access at the falling edge and record what it must return.
  task automatic access(input glb_web_t web, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    @(negedge clk);
    WEB        = web;
    addr       = a;
    write_data = d;
    e.rd  = exp_rd;
    e.err = exp_err;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Compare one expected entry per clock, just after the edge that produced it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("read_data", read_data, e.rd);
      check("addr_err", 32'(addr_err), 32'(e.err));
    end
  end

  logic [31:0] exp_b2b;

  initial begin
    rst_n      = 1'b1;
    WEB        = 4'hF;
    addr       = '0;
    write_data = '0;
    dut.memory[0]      = 32'hCAFEF00D;
    dut.memory[16'h0100] = 32'h0;
    dut.memory[16'h1000] = 32'hDEADBEEF;
    dut.memory[16'h2000] = 32'hAABBCCDD;
    dut.memory[16'h3000] = 32'h0;
    dut.memory[16'h3FFF] = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    rst_n = 1'b0;

    // Preload visible after reset.
    access(4'hF, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);
    // Full write then read back.
`ifdef GLB_WRITE_FIRST_EN
    access(4'h0, 32'h3000, 32'h12345678, 32'h12345678, 1'b0);
`else
    access(4'h0, 32'h3000, 32'h12345678, 32'h0, 1'b0);
`endif
    access(4'hF, 32'h3000, 32'h0, 32'h12345678, 1'b0);
    // Partial write of lanes 0 and 2.
`ifdef GLB_WRITE_FIRST_EN
    access(4'b1010, 32'h2000, 32'h11223344, 32'hAA22CC44, 1'b0);
`else
    access(4'b1010, 32'h2000, 32'h11223344, 32'hAABBCCDD, 1'b0);
`endif
    access(4'hF, 32'h2000, 32'h0, 32'hAA22CC44, 1'b0);
    // Same-address read-during-write.
`ifdef GLB_WRITE_FIRST_EN
    access(4'h0, 32'h0100, 32'h1, 32'h1, 1'b0);
    access(4'h0, 32'h0100, 32'h2, 32'h2, 1'b0);
`else
    access(4'h0, 32'h0100, 32'h1, 32'h0, 1'b0);
    access(4'h0, 32'h0100, 32'h2, 32'h1, 1'b0);
`endif
    access(4'hF, 32'h0100, 32'h0, 32'h2, 1'b0);
    // Out-of-range write suppressed, flag set, then cleared by a legal read.
    access(4'h0, 32'h0001_0000, 32'hFFFFFFFF, 32'h0, 1'b1);
    access(4'hF, 32'h0000_0000, 32'h0, 32'hCAFEF00D, 1'b0);
    access(4'hF, 32'h8000_3000, 32'h0, 32'h0, 1'b1);
    // Top word, back-to-back with single lane write.
    exp_b2b = 32'h5A5A5A5A;
`ifdef GLB_WRITE_FIRST_EN
    access(4'h0, 32'h3FFF, exp_b2b, exp_b2b, 1'b0);
    access(4'b0111, 32'h3FFF, 32'hC3000000, 32'hC35A5A5A, 1'b0);
`else
    access(4'h0, 32'h3FFF, exp_b2b, 32'h0, 1'b0);
    access(4'b0111, 32'h3FFF, 32'hC3000000, exp_b2b, 1'b0);
`endif
    access(4'hF, 32'h3FFF, 32'h0, 32'hC35A5A5A, 1'b0);
    access(4'hF, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();

    check("mem_3000", dut.memory[12288], 32'h12345678);
    check("mem_0", dut.memory[0], 32'hCAFEF00D);
    check("mem_1000", dut.memory[16'h1000], 32'hDEADBEEF);

    // Mid-cycle asynchronous reset after a nonzero read; write during reset must not land.
    @(posedge clk);
    #2;
    check("pre_rst_read", read_data, 32'hDEADBEEF);
    rst_n = 1'b1;
    #1;
    check("async_rst_read", read_data, 32'h0);
    check("async_rst_err", 32'(addr_err), 32'h0);
    @(negedge clk);
    WEB        = 4'h0;
    addr       = 32'h1000;
    write_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    check("held_rst_read", read_data, 32'h0);
    @(negedge clk);
    WEB   = 4'hF;
    rst_n = 1'b0;
    check("mem_after_rst", dut.memory[16'h1000], 32'hDEADBEEF);
    access(4'hF, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);
    access(4'hF, 32'h2000, 32'h0, 32'hAA22CC44, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sram_64kb

// File: doc/sram_64kb.md
# sram_64kb

Single-port 64 KB global buffer (GLB) storage: 16384 words × 32 bits, with per-byte active-low write enables and a registered one-cycle read port. It is the shared scratch memory between the token engine and the rest of the accelerator, holding weights, ifmap, ipsum, bias and opsum regions at engine-programmed base addresses. The word array is reachable hierarchically as `memory` so benches can preload it and inspect it.

## Interface
- Parameters:
- DEPTH, 16384, number of 32-bit words
- ADDR_W, 14, word-index bits taken from `addr`
- Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-high reset (asserted when 1, despite the legacy name)
- WEB  in  4  byte write enables, active low; bit i controls byte lane i (bits 8i+7:8i)
- addr  in  32  word address; `addr[13:0]` selects the word, `addr[31:14]` must be zero
- write_data  in  32  write data, lanes gated by WEB
- read_data  out  32  registered read data
- addr_err  out  1  registered flag: previous access had `addr[31:14] != 0`

## Operation
- Storage: unpacked array `memory[0:DEPTH-1]` of 32-bit words; name is fixed (bench preloads it with `$readmemh` and checks it directly, e.g. opsum at word 0x3000 = 12288).
- Addressing is word-granular: index = `addr[13:0]`; no byte-to-word shift.
- Every cycle is an access: write lanes where `WEB[i]==0`; read always performed.
- `WEB==4'hF`: pure read. Any zero bit: partial/full write of the selected lanes only; other lanes keep their value.
- Out-of-range address (`addr[31:14] != 0`): writes suppressed entirely; `read_data` returns 0; `addr_err` set to 1 for that access.
- Reset clears `read_data` and `addr_err` only; `memory` contents are never cleared by reset (preload must survive reset).
- X on WEB bits is treated as no-write for that lane.

## Timing
- Read latency 1 cycle: address at edge N → `read_data` valid after edge N, held until the next edge.
- Writes commit at the rising edge they are presented on; visible to a read issued the following cycle.
- Same-address read-during-write (default): read-first — `read_data` returns the pre-write word.
- Reset: `read_data`=0, `addr_err`=0 immediately on assertion (asynchronous), remaining 0 while asserted; no writes occur during reset. Reset mid-write aborts that write.
- Back-to-back accesses at full rate; no stall or handshake.

## Configuration
- `GLB_WRITE_FIRST_EN`: when defined, same-address read-during-write returns the merged new word (old bytes where WEB=1, write_data bytes where WEB=0). When undefined, read-first behaviour above. No other behaviour changes.

## Structure
- Shared package `glb_pkg`: `GLB_DEPTH=16384`, `GLB_ADDR_W=14`, `GLB_DATA_W=32`, `GLB_BYTES=4`, typedef `glb_word_t` (logic [31:0]), typedef `glb_web_t` (logic [3:0]).
- Byte-merge is a local function (`merge(old, wdata, web)`); no sub-module needed.

## Test plan
- Preload `memory[0x1000]=32'hDEADBEEF`, reset pulse, WEB=F addr=0x1000 → `read_data=32'hDEADBEEF` one cycle later; preload unchanged by reset.
- Full write WEB=0, addr=0x3000, data=32'h12345678; next cycle read → 32'h12345678; `memory[12288]==32'h12345678`.
- Partial write WEB=4'b1010 over 32'hAABBCCDD with data 32'h11223344 → word becomes 32'hAA22CC44.
- Same-address write 32'h0000_0001 then simultaneous read/write 32'h0000_0002 → `read_data=1` (default) or 2 with `GLB_WRITE_FIRST_EN`.
- addr=0x0001_0000, WEB=0, data=32'hFFFFFFFF → `addr_err=1`, `read_data=0`, `memory[0]` unchanged.
- Assert rst_n=1 mid-stream after read of nonzero word → `read_data` drops to 0 asynchronously; `memory` intact after release.
